mod_issue_ctrl: RTL and testbench

- Initiator side of the multicycle mod handshake used by the MIPS datapath ALU.
- Accepts a mod request (alu_ctr = 3'b111) from the decode/execute stage and launches the mod unit with a one-cycle start pulse.
- Holds the operands stable and stalls the pipeline until the unit's done arrives.
- Returns the result to writeback as a one-cycle valid. A timeout guards against a hung unit, and divide-by-zero is resolved locally without launching.

---
 rtl/mips_alu_pkg.sv | 14 +
 rtl/mod_issue_ctrl_if.sv | 24 ++
 rtl/mod_timeout_ctr.sv | 28 ++
 rtl/mod_issue_ctrl.sv | 99 +++++++++
 tb/tb_mod_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions for the multicycle mod issue path.
package mips_alu_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam logic [2:0]  ALU_CTR_MOD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mod_state_t;

endpackage

// File: rtl/mod_issue_ctrl_if.sv
// Handshake between the mod issue controller (master) and the mod unit (slave).
interface mod_issue_ctrl_if
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             mod_start;
  logic [WIDTH-1:0] mod_a;
  logic [WIDTH-1:0] mod_b;
  logic             mod_done;
  logic [WIDTH-1:0] mod_result;

  modport master (
    output mod_start, mod_a, mod_b,
    input  mod_done, mod_result
  );

  modport slave (
    input  mod_start, mod_a, mod_b,
    output mod_done, mod_result
  );

endinterface

// File: rtl/mod_timeout_ctr.sv
// WAIT-cycle counter for the mod handshake; expired flags the last allowed cycle.
module mod_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mod_issue_ctrl.sv
// Issues mod operations to the multicycle mod unit, stalls the pipeline until
// completion, and returns the result (or a local error) to writeback.
module mod_issue_ctrl
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_ctr,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  output logic              stall,
  mod_issue_ctrl_if.master  mod_bus,
  output logic              wb_valid,
  output logic [WIDTH-1:0]  wb_result,
  output logic              wb_err,
  output logic              busy
);

  mod_state_t state;
  logic       accept;
  logic       expired;

  assign accept = req_valid && (req_ctr == ALU_CTR_MOD);
  assign stall  = ((state == ST_IDLE) && accept) || (state == ST_LAUNCH) || (state == ST_WAIT);

  mod_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == ST_LAUNCH),
    .en      (state == ST_WAIT),
    .expired (expired)
  );

  // Strobes and busy are registered alongside the next-state decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      mod_bus.mod_start <= 1'b0;
      mod_bus.mod_a     <= '0;
      mod_bus.mod_b     <= '0;
      wb_valid          <= 1'b0;
      wb_result         <= '0;
      wb_err            <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (req_b != '0) begin
              mod_bus.mod_a     <= req_a;
              mod_bus.mod_b     <= req_b;
              mod_bus.mod_start <= 1'b1;
              state             <= ST_LAUNCH;
            end else begin
              wb_result <= req_a;
              wb_err    <= 1'b1;
              wb_valid  <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_LAUNCH: begin
          mod_bus.mod_start <= 1'b0;
          state             <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over a timeout expiring in the same cycle
          if (mod_bus.mod_done) begin
            wb_result <= mod_bus.mod_result;
            wb_err    <= 1'b0;
            wb_valid  <= 1'b1;
            state     <= ST_DONE;
          end else if (expired) begin
            wb_result <= '0;
            wb_err    <= 1'b1;
            wb_valid  <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          wb_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_issue_ctrl.sv
// Self-checking bench for mod_issue_ctrl: directed vector table, hand-written
// corner sequences, and randomized operations against a transaction-level model.
module tb_mod_issue_ctrl;
  import mips_alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int          TO = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [2:0]    req_ctr;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          stall;
  logic          wb_valid;
  logic [W-1:0]  wb_result;
  logic          wb_err;
  logic          busy;

  mod_issue_ctrl_if #(.WIDTH(W)) mbus ();

  mod_issue_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ctr   (req_ctr),
    .req_a     (req_a),
    .req_b     (req_b),
    .stall     (stall),
    .mod_bus   (mbus),
    .wb_valid  (wb_valid),
    .wb_result (wb_result),
    .wb_err    (wb_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] last_res;
  logic         last_err;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;      // WAIT cycle on which the unit answers, 0 = never
    logic [W-1:0] mres;
    int           stale;  // cycle (1 = LAUNCH) with a bogus done, 0 = none
    int           lat;    // cycles from accept to wb_valid
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b required=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level expectation from the operation's rules.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input int n,
                           input logic [W-1:0] mres,
                           output int lat, output logic [W-1:0] res, output logic err);
    if (b == '0) begin
      lat = 1; res = a; err = 1'b1;
    end else if (n >= 1 && n <= TO) begin
      lat = 2 + n; res = mres; err = 1'b0;
    end else begin
      lat = 2 + TO; res = '0; err = 1'b1;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int n,
                        input logic [W-1:0] mres, input int stale, input int lat,
                        input logic [W-1:0] res, input logic err);
    logic launched;
    launched = (b != '0);
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk("hold_result", wb_result, last_res);
    chk1("hold_err", wb_err, last_err);
    req_valid = 1'b1; req_ctr = ALU_CTR_MOD; req_a = a; req_b = b;
    mbus.mod_done = 1'b0;
    #1;
    chk1("accept_stall", stall, 1'b1);
    chk1("accept_start", mbus.mod_start, 1'b0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk1("mod_start", mbus.mod_start, launched && (c == 1));
      chk1("stall", stall, c < lat);
      chk1("wb_valid", wb_valid, c == lat);
      if (launched && c < lat) begin
        chk("mod_a", mbus.mod_a, a);
        chk("mod_b", mbus.mod_b, b);
      end
      if (c == lat) begin
        chk("wb_result", wb_result, res);
        chk1("wb_err", wb_err, err);
      end
      mbus.mod_done   = (c < lat) && ((n > 0 && c == n + 1) || c == stale);
      mbus.mod_result = (n > 0 && c == n + 1) ? mres : ~mres;
    end
    last_res = res;
    last_err = err;
  endtask

  task automatic idle_cycles(input int k, input logic stale_done);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_wb_valid", wb_valid, 1'b0);
      req_valid = 1'b0;
      mbus.mod_done = stale_done;
      mbus.mod_result = $urandom;
      #1;
      chk1("idle_stall", stall, 1'b0);
    end
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk("idle_hold", wb_result, last_res);
    mbus.mod_done = 1'b0;
  endtask

  task automatic non_mod(input logic [2:0] ctr);
    @(negedge clk);
    chk1("nm_busy", busy, 1'b0);
    req_valid = 1'b1; req_ctr = ctr; req_a = $urandom; req_b = $urandom | 32'd1;
    mbus.mod_done = 1'b0;
    #1;
    chk1("nm_stall", stall, 1'b0);
    chk1("nm_start", mbus.mod_start, 1'b0);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    req_valid = 1'b1; req_ctr = ALU_CTR_MOD; req_a = 32'd50; req_b = 32'd6;
    mbus.mod_done = 1'b0;
    @(negedge clk);
    chk1("rst_launch", mbus.mod_start, 1'b1);
    @(negedge clk);
    chk1("rst_wait_busy", busy, 1'b1);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_start", mbus.mod_start, 1'b0);
    chk("rst_mod_a", mbus.mod_a, '0);
    chk("rst_mod_b", mbus.mod_b, '0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_result", wb_result, '0);
    chk1("rst_wb_err", wb_err, 1'b0);
    @(negedge clk);
    reset = 1'b1; mbus.mod_done = 1'b1; mbus.mod_result = 32'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mbus.mod_done = 1'b0;
      chk1("post_rst_wb_valid", wb_valid, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end
    last_res = '0;
    last_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [W-1:0] res;
    logic         err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mres;
    int           n;
    int           kind;

    reset = 1'b1; req_valid = 1'b0; req_ctr = '0; req_a = '0; req_b = '0;
    mbus.mod_done = 1'b0; mbus.mod_result = '0;
    last_res = '0; last_err = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_start", mbus.mod_start, 1'b0);
    chk("reset_mod_a", mbus.mod_a, '0);
    chk("reset_mod_b", mbus.mod_b, '0);
    chk1("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_wb_result", wb_result, '0);
    chk1("reset_wb_err", wb_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    vecs[0] = '{32'd17,  32'd5, 3, 32'd2, 0, 5, 32'd2,   1'b0}; // basic
    vecs[1] = '{32'd9,   32'd0, 0, 32'd0, 0, 1, 32'd9,   1'b1}; // divide by zero
    vecs[2] = '{32'd123, 32'd4, 0, 32'd3, 0, 6, 32'd0,   1'b1}; // timeout
    vecs[3] = '{32'd200, 32'd9, 4, 32'd2, 0, 6, 32'd2,   1'b0}; // done at expiry
    vecs[4] = '{32'd100, 32'd7, 1, 32'd2, 0, 3, 32'd2,   1'b0}; // back-to-back 1
    vecs[5] = '{32'd8,   32'd3, 2, 32'd2, 0, 4, 32'd2,   1'b0}; // back-to-back 2
    vecs[6] = '{32'd45,  32'd6, 2, 32'd3, 1, 4, 32'd3,   1'b0}; // stale done in LAUNCH

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].mres, vecs[i].stale,
             vecs[i].lat, vecs[i].res, vecs[i].err);

    non_mod(3'b010);
    idle_cycles(3, 1'b1);
    run_op(32'd8, 32'd3, 1, 32'd2, 0, 3, 32'd2, 1'b0);
    reset_mid_wait();
    run_op(32'd31, 32'd10, 2, 32'd1, 0, 4, 32'd1, 1'b0);

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        non_mod(3'($urandom_range(0, 6)));
      end else if (kind == 2) begin
        idle_cycles($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1000));
        n = $urandom_range(0, 7);
        mres = (b != '0) ? (a % b) : '0;
        ref_model(a, b, n, mres, lat, res, err);
        run_op(a, b, n, mres, 0, lat, res, err);
      end
    end

    idle_cycles(1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
